// File: rtl/mem_port_arbiter.sv
// Shares the single memory data port between instruction fetch and load/store.
// Data has priority, a starvation counter forces fetch progress, and a watchdog aborts hung reads.
module mem_port_arbiter #(
  parameter int AW           = 12,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [31:0]   if_instr,
  output logic          if_valid,
  input  logic          d_ren,
  input  logic          d_wen,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  input  logic [3:0]    d_bsel,
  output logic [31:0]   d_rdata,
  output logic          d_ready,
  output logic [AW-1:0] m_addr,
  output logic [31:0]   m_wdata,
  output logic [3:0]    m_bsel,
  output logic          m_ren,
  output logic          m_wen,
  input  logic [31:0]   m_rdata,
  input  logic          m_ready,
  output logic          busy,
  output logic          err_timeout
);

  // Handshakes: a requester holds its request until its one-cycle acknowledge
  // (if_valid / d_ready); the memory takes a one-cycle m_ren/m_wen command and
  // answers a read with a single m_ready cycle carrying m_rdata.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);

  logic [1:0]  state;
  logic        owner_d;
  logic        op_wr;
  logic [3:0]  starve_cnt;
  logic [7:0]  wcnt;

  logic        d_req;
  logic        fetch_turn;
  logic        wait_done;
  logic [31:0] rd_val;

  assign d_req      = d_ren | d_wen;
  assign fetch_turn = if_req && (starve_cnt == STARVE_MAX);
  assign wait_done  = m_ready || (wcnt == WAIT_LAST);
  // An aborted read returns zero rather than whatever the bus happens to hold.
  assign rd_val     = m_ready ? m_rdata : 32'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      owner_d     <= 1'b0;
      op_wr       <= 1'b0;
      starve_cnt  <= '0;
      wcnt        <= '0;
      m_addr      <= '0;
      m_wdata     <= '0;
      m_bsel      <= '0;
      m_ren       <= 1'b0;
      m_wen       <= 1'b0;
      if_instr    <= '0;
      if_valid    <= 1'b0;
      d_rdata     <= '0;
      d_ready     <= 1'b0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (d_req && !fetch_turn) begin
            state   <= S_ISSUE;
            busy    <= 1'b1;
            owner_d <= 1'b1;
            op_wr   <= d_wen;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
            m_bsel  <= d_bsel;
            m_wen   <= d_wen;
            m_ren   <= !d_wen;
            if (!if_req)
              starve_cnt <= '0;
            else if (starve_cnt != STARVE_MAX)
              starve_cnt <= starve_cnt + 4'd1;
          end else if (if_req) begin
            state      <= S_ISSUE;
            busy       <= 1'b1;
            owner_d    <= 1'b0;
            op_wr      <= 1'b0;
            m_addr     <= if_addr;
            m_wdata    <= '0;
            m_bsel     <= '0;
            m_wen      <= 1'b0;
            m_ren      <= 1'b1;
            starve_cnt <= '0;
          end
        end

        S_ISSUE: begin
          m_ren <= 1'b0;
          m_wen <= 1'b0;
          wcnt  <= '0;
          if (op_wr) begin
            state   <= S_DONE;
            d_ready <= 1'b1;
            d_rdata <= '0;
          end else begin
            state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (wait_done) begin
            state <= S_DONE;
            if (!m_ready)
              err_timeout <= 1'b1;
            if (owner_d) begin
              d_ready <= 1'b1;
              d_rdata <= rd_val;
            end else begin
              if_valid <= 1'b1;
              if_instr <= rd_val;
            end
          end else begin
            wcnt <= wcnt + 8'd1;
          end
        end

        S_DONE: begin
          state    <= S_IDLE;
          busy     <= 1'b0;
          if_valid <= 1'b0;
          d_ready  <= 1'b0;
          if_instr <= '0;
          d_rdata  <= '0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized two-requester run
// checked against a transaction-level model (priority rule, latency formula, reference memory).
module tb_mem_port_arbiter;

  localparam int AW           = 12;
  localparam int STARVE_LIMIT = 4;
  localparam int TIMEOUT      = 64;

  logic          clk;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [31:0]   if_instr;
  logic          if_valid;
  logic          d_ren;
  logic          d_wen;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic [3:0]    d_bsel;
  logic [31:0]   d_rdata;
  logic          d_ready;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata;
  logic [3:0]    m_bsel;
  logic          m_ren;
  logic          m_wen;
  logic [31:0]   m_rdata;
  logic          m_ready;
  logic          busy;
  logic          err_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] mem     [0:4095];
  logic [31:0] ref_mem [0:4095];

  int mem_lat;
  int lat_left;
  bit rd_pend;

  int          t_cyc, t_who, t_ren, t_wen, t_both, t_ren_cyc;
  logic [31:0] t_data;

  mem_port_arbiter #(
    .AW(AW), .STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_instr(if_instr), .if_valid(if_valid),
    .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata), .d_bsel(d_bsel),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_bsel(m_bsel), .m_ren(m_ren), .m_wen(m_wen),
    .m_rdata(m_rdata), .m_ready(m_ready),
    .busy(busy), .err_timeout(err_timeout)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: writes commit at the command edge; a read answers after mem_lat low cycles.
  always @(posedge clk) begin
    if (reset) begin
      rd_pend = 1'b0;
      m_ready <= 1'b0;
      m_rdata <= '0;
    end else begin
      m_ready <= 1'b0;
      m_rdata <= $urandom;
      if (m_wen)
        for (int b = 0; b < 4; b++)
          if (m_bsel[b]) mem[m_addr][8*b +: 8] = m_wdata[8*b +: 8];
      if (m_ren) begin
        rd_pend  = 1'b1;
        lat_left = mem_lat;
      end else if (rd_pend && lat_left > 0) begin
        lat_left--;
      end
      if (rd_pend && lat_left == 0) begin
        m_ready <= 1'b1;
        m_rdata <= mem[m_addr];
        rd_pend = 1'b0;
      end
    end
  end

  // driver tasks
  task automatic clear_reqs();
    if_req = 1'b0; if_addr = '0;
    d_ren = 1'b0; d_wen = 1'b0; d_addr = '0; d_wdata = '0; d_bsel = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_reqs();
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [31:0] v);
    mem[a]     = v;
    ref_mem[a] = v;
  endtask

  task automatic ref_write(input logic [AW-1:0] a, input logic [31:0] w, input logic [3:0] be);
    for (int b = 0; b < 4; b++)
      if (be[b]) ref_mem[a][8*b +: 8] = w[8*b +: 8];
  endtask

  // Called at the negedge of cycle 0 with requests already driven; returns at the ack cycle.
  task automatic run_txn(input int max_cyc);
    t_cyc = 0; t_who = 0; t_ren = 0; t_wen = 0; t_both = 0; t_ren_cyc = -1; t_data = '0;
    while (t_who == 0 && t_cyc < max_cyc) begin
      @(negedge clk);
      t_cyc++;
      if (m_ren) begin t_ren++; t_ren_cyc = t_cyc; end
      if (m_wen) t_wen++;
      if (m_ren && m_wen) t_both++;
      if (if_valid && d_ready) t_who = 3;
      else if (if_valid) begin t_who = 1; t_data = if_instr; end
      else if (d_ready) begin t_who = 2; t_data = d_rdata; end
    end
  endtask

  function automatic int pick_lat();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return TIMEOUT - 1;
    if (r == 1) return TIMEOUT;
    return $urandom_range(0, 6);
  endfunction

  // scenarios
  task automatic test_reset();
    logic [117:0] outs;
    reset = 1'b1;
    if_req = 1'b1; if_addr = 12'h123; d_wen = 1'b1; d_addr = 12'h321;
    repeat (3) @(negedge clk);
    outs = {if_instr, if_valid, d_rdata, d_ready, m_addr, m_wdata, m_bsel, m_ren, m_wen, busy, err_timeout};
    n_checks++; if (outs !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", outs); end
    reset = 1'b0;
    clear_reqs();
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_fetch();
    preload(12'h010, 32'h00500093);
    mem_lat = 7;
    if_addr = 12'h010; if_req = 1'b1;
    run_txn(200);
    if_req = 1'b0;
    n_checks++; if (t_who !== 1) begin n_fail++; $display("FAIL fetch_owner: got %0d expected 1", t_who); end
    n_checks++; if (t_cyc !== 10) begin n_fail++; $display("FAIL fetch_cycle: got %0d expected 10", t_cyc); end
    n_checks++; if (t_data !== 32'h00500093) begin n_fail++; $display("FAIL fetch_data: got %h expected 00500093", t_data); end
    n_checks++; if (t_ren !== 1 || t_ren_cyc !== 1) begin n_fail++; $display("FAIL fetch_m_ren: got %0d pulses last at %0d expected 1 at 1", t_ren, t_ren_cyc); end
    n_checks++; if (t_wen !== 0) begin n_fail++; $display("FAIL fetch_m_wen: got %0d expected 0", t_wen); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fetch_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_store_load();
    int lat;
    d_wen = 1'b1; d_addr = 12'h020; d_wdata = 32'hAABBCCDD; d_bsel = 4'b0011;
    run_txn(50);
    d_wen = 1'b0;
    ref_write(12'h020, 32'hAABBCCDD, 4'b0011);
    n_checks++; if (t_who !== 2 || t_cyc !== 2) begin n_fail++; $display("FAIL store_ack: got owner %0d cycle %0d expected 2 at 2", t_who, t_cyc); end
    n_checks++; if (t_data !== 32'd0) begin n_fail++; $display("FAIL store_rdata: got %h expected 0", t_data); end
    n_checks++; if (t_wen !== 1 || t_ren !== 0) begin n_fail++; $display("FAIL store_strobes: got wen %0d ren %0d expected 1 0", t_wen, t_ren); end
    n_checks++; if (m_bsel !== 4'b0011) begin n_fail++; $display("FAIL store_bsel: got %b expected 0011", m_bsel); end
    @(negedge clk);
    lat = $urandom_range(0, 5);
    mem_lat = lat;
    d_ren = 1'b1; d_addr = 12'h020;
    run_txn(100);
    d_ren = 1'b0;
    n_checks++; if (t_data !== 32'h0000CCDD) begin n_fail++; $display("FAIL load_after_store: got %h expected 0000ccdd", t_data); end
    n_checks++; if (t_who !== 2 || t_cyc !== lat + 3) begin n_fail++; $display("FAIL load_ack: got owner %0d cycle %0d expected 2 at %0d", t_who, t_cyc, lat + 3); end
    @(negedge clk);
  endtask

  task automatic test_both_strobes();
    d_ren = 1'b1; d_wen = 1'b1; d_addr = 12'h030; d_wdata = 32'h12345678; d_bsel = 4'b1111;
    run_txn(50);
    d_ren = 1'b0; d_wen = 1'b0;
    ref_write(12'h030, 32'h12345678, 4'b1111);
    n_checks++; if (t_who !== 2 || t_cyc !== 2) begin n_fail++; $display("FAIL both_ack: got owner %0d cycle %0d expected 2 at 2", t_who, t_cyc); end
    n_checks++; if (t_ren !== 0 || t_wen !== 1) begin n_fail++; $display("FAIL both_strobes: got ren %0d wen %0d expected 0 1", t_ren, t_wen); end
    @(negedge clk);
    mem_lat = 0;
    d_ren = 1'b1; d_addr = 12'h030;
    run_txn(50);
    d_ren = 1'b0;
    n_checks++; if (t_data !== 32'h12345678 || t_cyc !== 3) begin n_fail++; $display("FAIL both_readback: got %h at %0d expected 12345678 at 3", t_data, t_cyc); end
    @(negedge clk);
  endtask

  task automatic test_starvation();
    int exp_who;
    do_reset();
    mem_lat = 1;
    if_req = 1'b1; if_addr = 12'h040;
    d_ren = 1'b1; d_addr = 12'h100;
    for (int i = 0; i < 2 * (STARVE_LIMIT + 1); i++) begin
      run_txn(100);
      exp_who = ((i % (STARVE_LIMIT + 1)) == STARVE_LIMIT) ? 1 : 2;
      n_checks++; if (t_who !== exp_who) begin n_fail++; $display("FAIL starve_grant_%0d: got %0d expected %0d", i, t_who, exp_who); end
      n_checks++; if (t_cyc !== 4) begin n_fail++; $display("FAIL starve_latency_%0d: got %0d expected 4", i, t_cyc); end
      if (t_who == 1) if_addr = if_addr + 12'd1;
      else d_addr = d_addr + 12'd1;
      @(negedge clk);
    end
    clear_reqs();
    @(negedge clk);
  endtask

  task automatic test_timeout();
    preload(12'h051, 32'hCAFEF00D);
    mem_lat = TIMEOUT - 1;
    d_ren = 1'b1; d_addr = 12'h051;
    run_txn(200);
    d_ren = 1'b0;
    n_checks++; if (t_cyc !== TIMEOUT + 2 || t_data !== 32'hCAFEF00D) begin n_fail++; $display("FAIL late_ready: got %h at %0d expected cafef00d at %0d", t_data, t_cyc, TIMEOUT + 2); end
    n_checks++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL late_ready_err: got %b expected 0", err_timeout); end
    @(negedge clk);
    mem_lat = 100000;
    d_ren = 1'b1; d_addr = 12'h050;
    run_txn(200);
    d_ren = 1'b0;
    n_checks++; if (t_who !== 2 || t_cyc !== TIMEOUT + 2) begin n_fail++; $display("FAIL timeout_ack: got owner %0d cycle %0d expected 2 at %0d", t_who, t_cyc, TIMEOUT + 2); end
    n_checks++; if (t_data !== 32'd0) begin n_fail++; $display("FAIL timeout_data: got %h expected 0", t_data); end
    n_checks++; if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %b expected 1", err_timeout); end
    repeat (3) @(negedge clk);
    mem_lat = 0;
    if_req = 1'b1; if_addr = 12'h010;
    run_txn(50);
    if_req = 1'b0;
    n_checks++; if (t_data !== 32'h00500093 || err_timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: got data %h err %b expected 00500093 1", t_data, err_timeout); end
    @(negedge clk);
  endtask

  task automatic test_reset_midread();
    logic [117:0] outs;
    int stray;
    mem_lat = 20;
    if_addr = 12'h010; if_req = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b1; if_req = 1'b0;
    @(negedge clk);
    outs = {if_instr, if_valid, d_rdata, d_ready, m_addr, m_wdata, m_bsel, m_ren, m_wen, busy, err_timeout};
    n_checks++; if (outs !== '0) begin n_fail++; $display("FAIL midread_reset_outputs: got %h expected 0", outs); end
    reset = 1'b0;
    stray = 0;
    repeat (40) begin
      @(negedge clk);
      if (if_valid || d_ready || busy) stray++;
    end
    n_checks++; if (stray !== 0) begin n_fail++; $display("FAIL midread_no_ack: got %0d active cycles expected 0", stray); end
    mem_lat = 3;
    if_addr = 12'h010; if_req = 1'b1;
    run_txn(100);
    if_req = 1'b0;
    n_checks++; if (t_who !== 1 || t_cyc !== 6 || t_data !== 32'h00500093) begin n_fail++; $display("FAIL midread_refetch: got owner %0d cycle %0d data %h expected 1 6 00500093", t_who, t_cyc, t_data); end
    @(negedge clk);
  endtask

  task automatic test_random();
    bit          f_pend, d_pend, win_d, exp_err;
    int          sc, f_n, d_n, d_op, e_lat, exp_who, exp_ren;
    logic [AW-1:0] fa, da;
    logic [31:0] dw, e_data, got_exp;
    logic [3:0]  db;
    do_reset();
    f_pend = 0; d_pend = 0; exp_err = 0; sc = 0;
    f_n = 0; d_n = 0; d_op = 0; fa = '0; da = '0; dw = '0; db = '0;
    for (int it = 0; it < 60; it++) begin
      if (!f_pend && $urandom_range(0, 1) == 1) begin
        f_pend = 1; fa = 12'($urandom_range(0, 15)); f_n = pick_lat();
        if_req = 1'b1; if_addr = fa;
      end
      if (!d_pend && ($urandom_range(0, 1) == 1 || !f_pend)) begin
        d_pend = 1; d_op = $urandom_range(0, 2);
        da = 12'($urandom_range(0, 15)); dw = $urandom; db = 4'($urandom_range(0, 15)); d_n = pick_lat();
        d_ren = (d_op != 1); d_wen = (d_op != 0); d_addr = da; d_wdata = dw; d_bsel = db;
      end
      win_d = d_pend && !(f_pend && sc == STARVE_LIMIT);
      if (win_d) begin
        exp_who = 2;
        if (d_op != 0) begin
          e_lat = 2; e_data = '0; exp_ren = 0;
          ref_write(da, dw, db);
        end else begin
          e_lat = ((d_n >= TIMEOUT) ? TIMEOUT - 1 : d_n) + 3; exp_ren = 1;
          e_data = (d_n >= TIMEOUT) ? 32'd0 : ref_mem[da];
          if (d_n >= TIMEOUT) exp_err = 1;
        end
        mem_lat = d_n;
        sc = f_pend ? ((sc < STARVE_LIMIT) ? sc + 1 : sc) : 0;
      end else begin
        exp_who = 1; exp_ren = 1;
        e_lat = ((f_n >= TIMEOUT) ? TIMEOUT - 1 : f_n) + 3;
        e_data = (f_n >= TIMEOUT) ? 32'd0 : ref_mem[fa];
        if (f_n >= TIMEOUT) exp_err = 1;
        mem_lat = f_n;
        sc = 0;
      end
      exp_q.push_back(e_data);
      run_txn(200);
      got_exp = exp_q.pop_front();
      n_checks++; if (t_who !== exp_who) begin n_fail++; $display("FAIL rand_owner_%0d: got %0d expected %0d", it, t_who, exp_who); end
      n_checks++; if (t_cyc !== e_lat) begin n_fail++; $display("FAIL rand_latency_%0d: got %0d expected %0d", it, t_cyc, e_lat); end
      n_checks++; if (t_data !== got_exp) begin n_fail++; $display("FAIL rand_data_%0d: got %h expected %h", it, t_data, got_exp); end
      n_checks++; if (t_ren !== exp_ren || t_both !== 0) begin n_fail++; $display("FAIL rand_strobes_%0d: got ren %0d both %0d expected %0d 0", it, t_ren, t_both, exp_ren); end
      n_checks++; if (err_timeout !== exp_err) begin n_fail++; $display("FAIL rand_err_%0d: got %b expected %b", it, err_timeout, exp_err); end
      if (win_d) begin d_pend = 0; d_ren = 1'b0; d_wen = 1'b0; end
      else begin f_pend = 0; if_req = 1'b0; end
      @(negedge clk);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rand_idle_busy_%0d: got %b expected 0", it, busy); end
    end
    clear_reqs();
  endtask

  initial begin
    reset = 1'b1;
    mem_lat = 0; lat_left = 0; rd_pend = 1'b0;
    clear_reqs();
    for (int i = 0; i < 4096; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    test_reset();
    test_fetch();
    test_store_load();
    test_both_strobes();
    test_starvation();
    test_timeout();
    test_reset_midread();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
